// File: rtl/semaforo_botoeira.sv
// Purpose: pedestrian push-button front end; debounces btn_raw, issues one-cycle bt, drives wait/served lamps, flags bad light codes.
// Latency: clean btn_raw rise -> bt 2 + DEB_CYCLES + 1 cycles after first sampled high; espera/servido/erro are registered.
// Backpressure: none; bt is fire-and-forget, further presses are dropped until service completes and the holdoff expires.
//
// Ports:
//   clk      rising-edge system clock
//   rst      asynchronous active-high reset
//   btn_raw  raw, bouncing, asynchronous pedestrian button
//   A, B     controller light buses, one-hot: 100 green, 010 yellow, 001 red
//   bt       one-cycle request pulse to the controller
//   espera   wait lamp, accepted press until service begins
//   servido  high while bus A is red after a request
//   erro     sticky flag: A or B carried a non one-hot code
//
// Optional feature: define BOTOEIRA_TIMEOUT_EN to re-issue bt after TIMEOUT_CYCLES
// WAIT cycles without A turning red (unlimited retries). Undefined: WAIT never times out.
module semaforo_botoeira #(
    parameter int unsigned DEB_CYCLES     = 4,
    parameter int unsigned HOLDOFF_CYCLES = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    input  logic [2:0] A,
    input  logic [2:0] B,
    output logic       bt,
    output logic       espera,
    output logic       servido,
    output logic       erro
);

    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLDOFF_CYCLES);
    localparam logic [2:0]        LIGHT_RED = 3'b001;

    // Zero-length debounce/holdoff/timeout windows would break the counters below.
    if (DEB_CYCLES < 1 || HOLDOFF_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("semaforo_botoeira: DEB_CYCLES, HOLDOFF_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SERVE,
        ST_HOLD
    } state_t;

    function automatic logic code_bad(input logic [2:0] code);
        logic bad;
        unique case (code)
            3'b100, 3'b010, 3'b001: bad = 1'b0;
            default:                bad = 1'b1;
        endcase
        return bad;
    endfunction

    // ------------------------------------------------------------------
    // Button front end: 2-flop synchronizer, debouncer, press strobe
    // ------------------------------------------------------------------
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [1:0]       sync_fill_q, sync_fill_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q, deb_dly_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             arm_q, arm_d;
    logic             btn_s;
    logic             press;

    assign btn_s = sync2_q;

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        deb_cnt_d = '0;
        // Counter only runs while the synchronized level disagrees with the
        // accepted level; any agreeing sample restarts the qualification.
        if (btn_s != deb_q) begin
            if (deb_cnt_q == DEB_MAX) begin
                deb_d = btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        // sync_fill counts edges since reset; at 2 the synchronizer output is a
        // real sample rather than its reset value.
        sync_fill_d = (sync_fill_q == 2'd2) ? sync_fill_q : sync_fill_q + 2'd1;
        // A press is only honoured after a genuine released sample, so a button
        // held through reset cannot fire until it is released and pressed again.
        arm_d = arm_q | ((sync_fill_q == 2'd2) & ~btn_s);
    end

    assign press = deb_q & ~deb_dly_q & arm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync_fill_q <= 2'd0;
            deb_q       <= 1'b0;
            deb_dly_q   <= 1'b0;
            deb_cnt_q   <= '0;
            arm_q       <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync_fill_q <= sync_fill_d;
            deb_q       <= deb_d;
            deb_dly_q   <= deb_dly_d;
            deb_cnt_q   <= deb_cnt_d;
            arm_q       <= arm_d;
        end
    end

    // ------------------------------------------------------------------
    // Illegal light code monitor (sticky)
    // ------------------------------------------------------------------
    logic chk_en_q, chk_en_d;
    logic erro_q, erro_d;

    always_comb begin
        // Buses are still settling in the first cycle after reset release.
        chk_en_d = 1'b1;
        erro_d   = erro_q | (chk_en_q & (code_bad(A) | code_bad(B)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_en_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            chk_en_q <= chk_en_d;
            erro_q   <= erro_d;
        end
    end

    // ------------------------------------------------------------------
    // Request / service FSM with registered outputs
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              bt_q, bt_d;
    logic              espera_q, espera_d;
    logic              servido_q, servido_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0] hold_inc;
    logic              a_red;

    assign a_red    = (A == LIGHT_RED);
    assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);

`ifdef BOTOEIRA_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [WAIT_W-1:0] wait_inc;

    assign wait_inc = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
`endif

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
`ifdef BOTOEIRA_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (press) state_d = ST_REQ;
            end
            ST_REQ: begin
                // Always spend one WAIT cycle, even if A is already red.
                state_d = ST_WAIT;
`ifdef BOTOEIRA_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                if (a_red) begin
                    state_d = ST_SERVE;
                end
`ifdef BOTOEIRA_TIMEOUT_EN
                else if (wait_inc == WAIT_MAX) begin
                    // Controller never answered: retry the request.
                    state_d    = ST_REQ;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_inc;
                end
`endif
            end
            ST_SERVE: begin
                if (!a_red) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                hold_cnt_d = hold_inc;
                if (hold_inc == HOLD_MAX) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs decoded from the next state so they line up with state_q.
        bt_d      = (state_d == ST_REQ);
        espera_d  = (state_d == ST_REQ) || (state_d == ST_WAIT);
        servido_d = (state_d == ST_SERVE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bt_q       <= 1'b0;
            espera_q   <= 1'b0;
            servido_q  <= 1'b0;
            hold_cnt_q <= '0;
`ifdef BOTOEIRA_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bt_q       <= bt_d;
            espera_q   <= espera_d;
            servido_q  <= servido_d;
            hold_cnt_q <= hold_cnt_d;
`ifdef BOTOEIRA_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign bt      = bt_q;
    assign espera  = espera_q;
    assign servido = servido_q;
    assign erro    = erro_q;

endmodule

// File: tb/tb_semaforo_botoeira.sv
// Purpose: self-checking bench for semaforo_botoeira against a behavioural reference model.
// Latency: model is stepped once per rising edge; DUT outputs are compared on the falling edge.
// Backpressure: not applicable; stimulus is applied every cycle.
module tb_semaforo_botoeira;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int TMO  = 64;
    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic [2:0] A;
    logic [2:0] B;
    logic       bt;
    logic       espera;
    logic       servido;
    logic       erro;

    semaforo_botoeira #(
        .DEB_CYCLES    (DEB),
        .HOLDOFF_CYCLES(HOLD),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_raw),
        .A      (A),
        .B      (B),
        .bt     (bt),
        .espera (espera),
        .servido(servido),
        .erro   (erro)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int bt_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks what the pedestrian sees (lamps, pulses)
    // rather than controller states.
    // ------------------------------------------------------------------
    bit m_s1, m_s2;          // button as seen through the two-stage synchronizer
    bit m_deb, m_deb_prev;   // accepted button level, and its value one edge earlier
    bit m_arm;               // a real released sample has been seen since reset
    bit m_last;              // last synchronized sample
    int m_streak;            // length of the run of identical synchronized samples
    int m_age;               // edges since reset, saturating at 2
    bit m_bt, m_esp, m_srv, m_err, m_chk_on;
    int m_hold_left;         // remaining ignore-presses cycles after service
    int m_wait_age;          // cycles spent waiting since the last request

    function automatic bit legal(input logic [2:0] c);
        return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0; m_arm = 0; m_last = 0;
        m_streak = 0; m_age = 0;
        m_bt = 0; m_esp = 0; m_srv = 0; m_err = 0; m_chk_on = 0;
        m_hold_left = 0; m_wait_age = 0;
    endtask

    task automatic model_edge();
        bit press;
        bit x;
        bit a_red;
        if (rst) begin
            model_reset();
            return;
        end
        press = m_deb && !m_deb_prev && m_arm;
        a_red = (A == R);
        if (m_bt) begin
            m_bt       = 0;          // request issued; now waiting, lamp stays on
            m_wait_age = 0;
        end else if (m_esp) begin
            if (a_red) begin
                m_esp = 0;
                m_srv = 1;
            end
`ifdef BOTOEIRA_TIMEOUT_EN
            else begin
                m_wait_age++;
                if (m_wait_age == TMO) begin
                    m_bt       = 1;
                    m_wait_age = 0;
                end
            end
`endif
        end else if (m_srv) begin
            if (!a_red) begin
                m_srv       = 0;
                m_hold_left = HOLD;
            end
        end else if (m_hold_left > 0) begin
            m_hold_left--;
        end else if (press) begin
            m_bt  = 1;
            m_esp = 1;
        end

        if (m_chk_on && !(legal(A) && legal(B))) m_err = 1;
        m_chk_on = 1;

        x = m_s2;
        if (m_age >= 2 && !x) m_arm = 1;
        if (m_age < 2) m_age++;
        if (x == m_last) m_streak++;
        else m_streak = 1;
        m_last     = x;
        m_deb_prev = m_deb;
        // A new level is accepted once it has been seen on DEB+1 consecutive edges.
        if (x != m_deb && m_streak >= DEB + 1) m_deb = x;
        m_s2 = m_s1;
        m_s1 = btn_raw;
    endtask

    // One clock: drive inputs (called on a falling edge), step the model at the
    // rising edge, compare at the next falling edge.
    task automatic cycle(input bit r, input bit b, input logic [2:0] a, input logic [2:0] bb);
        rst     = r;
        btn_raw = b;
        A       = a;
        B       = bb;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("bt", bt, m_bt);
        chk("espera", espera, m_esp);
        chk("servido", servido, m_srv);
        chk("erro", erro, m_err);
        if (bt === 1'b1) bt_seen++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        int exp_bt;
        int cnt;
        bit         rb;
        logic [2:0] ra, rbb;
        bit         bounce [6];

        rst = 1'b1; btn_raw = 1'b0; A = G; B = G;
        model_reset();
        @(negedge clk);

        // Reset and quiet idle
        cycle(1, 0, G, G);
        cycle(1, 0, G, G);
        chk("reset_outputs", {bt, espera, servido, erro}, 4'b0000);
        repeat (20) cycle(0, 0, G, G);
        chk("idle_erro", erro, 0);

        // Bouncing press, then stable high
        bounce = '{1, 0, 1, 0, 1, 0};
        foreach (bounce[i]) cycle(0, bounce[i], G, G);
        lat = -1;
        bt_seen = 0;
        for (int k = 0; k < 30; k++) begin
            cycle(0, 1, G, G);
            if (bt === 1'b1 && lat < 0) begin
                lat = k;
                chk("espera_at_bt", espera, 1);
            end
        end
        chk("press_latency", lat, 2 + DEB + 1);

        // Second press while waiting, then lights cycle to red
        repeat (10) cycle(0, 0, G, G);
        repeat (10) cycle(0, 1, G, G);
        repeat (5)  cycle(0, 0, G, G);
        repeat (3)  cycle(0, 0, Y, G);
        chk("espera_before_red", espera, 1);
        cycle(0, 0, R, G);
        chk("servido_after_red", servido, 1);
        chk("espera_after_red", espera, 0);
        // Press during service / holdoff
        repeat (3) cycle(0, 1, R, G);
        cycle(0, 1, G, G);
        chk("servido_after_green", servido, 0);
        repeat (11) cycle(0, 1, G, G);
        repeat (20) cycle(0, 0, G, G);
        chk("bt_count_single", bt_seen, 1);

        // Timeout retry (or lack of it)
        cycle(1, 0, G, G);
        repeat (5) cycle(0, 0, G, G);
        bt_seen = 0;
        for (int k = 0; k < 160; k++) cycle(0, (k < 15), G, G);
`ifdef BOTOEIRA_TIMEOUT_EN
        exp_bt = 0;
        for (int t = 2 + DEB + 1; t < 160; t += TMO + 1) exp_bt++;
`else
        exp_bt = 1;
`endif
        chk("bt_count_timeout", bt_seen, exp_bt);
        repeat (3) cycle(0, 0, R, G);
        repeat (12) cycle(0, 0, G, G);

        // Reset mid-wait with the button still held
        repeat (12) cycle(0, 1, G, G);
        chk("espera_pre_reset", espera, 1);
        cycle(1, 1, G, G);
        chk("espera_in_reset", espera, 0);
        cycle(1, 1, G, G);
        bt_seen = 0;
        repeat (20) cycle(0, 1, G, G);
        chk("held_btn_no_bt", bt_seen, 0);
        repeat (10) cycle(0, 0, G, G);
        repeat (12) cycle(0, 1, G, G);
        chk("repress_bt", bt_seen, 1);
        repeat (4)  cycle(0, 0, R, G);
        repeat (12) cycle(0, 0, G, G);

        // Illegal codes: ignored in first cycle after reset, then sticky
        cycle(1, 0, G, G);
        cycle(0, 0, 3'b000, G);
        repeat (3) cycle(0, 0, G, G);
        chk("erro_first_cycle_masked", erro, 0);
        cycle(0, 0, 3'b011, G);
        chk("erro_set", erro, 1);
        repeat (5) cycle(0, 0, G, G);
        chk("erro_sticky", erro, 1);
        cycle(1, 0, G, G);
        chk("erro_cleared", erro, 0);
        cycle(0, 0, G, G);
        cycle(0, 0, G, 3'b110);
        chk("erro_bus_b", erro, 1);
        cycle(1, 0, G, G);

        // Randomized traffic
        rb = 0; ra = G; rbb = G;
        cnt = 0;
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(5) == 0) rb = ~rb;
            if ($urandom_range(5) == 0) begin
                case ($urandom_range(2))
                    0: ra = G;
                    1: ra = Y;
                    default: ra = R;
                endcase
            end
            if ($urandom_range(7) == 0) rbb = ($urandom_range(1) == 0) ? G : R;
            if ($urandom_range(299) == 0) ra = 3'($urandom_range(7));
            cycle(($urandom_range(199) == 0), rb, ra, rbb);
            if (!legal(ra)) ra = G;
            cnt++;
        end
        chk("random_cycles", cnt, 900);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
